// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - IF stage: PC, instruction-memory read handshake, IF/ID register
//
// Purpose: owns the fetch PC and issues one instruction-memory read at a time.
// It predicts not-taken (PC+1) and follows redirects from EX/ID. Returned words
// go into the IF/ID register. If IF/ID cannot accept a word, the word waits in a
// one-entry hold buffer.
//
// Ports:
//   clk, reset_n                 clock (rising edge), asynchronous active-low reset
//   pc_write, ir_write           hazard-unit permission to advance PC / load IF/ID
//   stall_IFID, flush_IFID       hold IF/ID / clear IF/ID to a bubble
//   redirect_valid, redirect_pc  PC redirect on jump or branch miss
//   i_readM, i_address           instruction-memory request and its address
//   i_data, i_inputReady         returned word, valid for one cycle per request
//   instr_IFID, pc_IFID          IF/ID instruction and its address
//   pc_plus1_IFID                IF/ID link value (pc_IFID + 1)
//   valid_IFID                   IF/ID holds a real instruction
//   fetch_wait                   IF/ID got a bubble because no word was available

module fetch_stage #(
  parameter int                   WORD_SIZE = 16,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 pc_write,
  input  logic                 ir_write,
  input  logic                 stall_IFID,
  input  logic                 flush_IFID,
  input  logic                 redirect_valid,
  input  logic [WORD_SIZE-1:0] redirect_pc,
  output logic                 i_readM,
  output logic [WORD_SIZE-1:0] i_address,
  input  logic [WORD_SIZE-1:0] i_data,
  input  logic                 i_inputReady,
  output logic [WORD_SIZE-1:0] instr_IFID,
  output logic [WORD_SIZE-1:0] pc_IFID,
  output logic [WORD_SIZE-1:0] pc_plus1_IFID,
  output logic                 valid_IFID,
  output logic                 fetch_wait
);

  typedef enum logic [1:0] {S_REQ, S_HOLD, S_DRAIN} state_t;

  state_t               state;
  logic [WORD_SIZE-1:0] pc;
  logic [WORD_SIZE-1:0] hold_data;
  logic [WORD_SIZE-1:0] pc_inc;
  logic [WORD_SIZE-1:0] redirect_tgt;
  logic [WORD_SIZE-1:0] load_data;
  logic                 advance;
  logic                 kill;
  logic                 mem_ready;
  logic                 load_ifid;

  assign advance      = pc_write & ir_write & ~stall_IFID;
  assign kill         = redirect_valid | flush_IFID;
  // A ready pulse counts only against an outstanding request.
  // i_readM is low in S_HOLD and in the issue cycle after reset.
  assign mem_ready    = i_readM & i_inputReady;
  assign pc_inc       = pc + WORD_SIZE'(1);
  assign redirect_tgt = redirect_valid ? redirect_pc : pc;

  // The word that may enter IF/ID this cycle: either fresh from memory, or
  // parked in the hold buffer.
  assign load_ifid = ~redirect_valid & advance &
                     (((state == S_REQ) & mem_ready) | (state == S_HOLD));
  assign load_data = (state == S_HOLD) ? hold_data : i_data;

  // Fetch FSM. While a request is outstanding in S_REQ, pc equals i_address.
  // Every entry to S_REQ issues the next request immediately. This keeps
  // i_readM high back-to-back when memory answers every cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_REQ;
      pc        <= RESET_PC;
      hold_data <= '0;
      i_readM   <= 1'b0;
      i_address <= '0;
    end else begin
      case (state)
        S_REQ: begin
          if (!i_readM) begin
            pc        <= redirect_tgt;
            i_readM   <= 1'b1;
            i_address <= redirect_tgt;
          end else if (i_inputReady) begin
            if (redirect_valid) begin
              pc        <= redirect_pc;
              i_address <= redirect_pc;
            end else if (advance) begin
              pc        <= pc_inc;
              i_address <= pc_inc;
            end else begin
              hold_data <= i_data;
              i_readM   <= 1'b0;
              state     <= S_HOLD;
            end
          end else if (redirect_valid) begin
            // The request cannot be withdrawn. Its answer is discarded in
            // S_DRAIN, and i_address is held meanwhile.
            pc    <= redirect_pc;
            state <= S_DRAIN;
          end
        end
        S_HOLD: begin
          if (redirect_valid) begin
            pc        <= redirect_pc;
            i_readM   <= 1'b1;
            i_address <= redirect_pc;
            state     <= S_REQ;
          end else if (advance) begin
            pc        <= pc_inc;
            i_readM   <= 1'b1;
            i_address <= pc_inc;
            state     <= S_REQ;
          end
        end
        S_DRAIN: begin
          pc <= redirect_tgt;
          if (i_inputReady) begin
            i_address <= redirect_tgt;
            state     <= S_REQ;
          end
        end
        default: begin
          state   <= S_REQ;
          i_readM <= 1'b0;
        end
      endcase
    end
  end

  // IF/ID register.
  // Priority: kill, then hold, then load, then a bubble flagged by fetch_wait.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instr_IFID    <= '0;
      pc_IFID       <= '0;
      pc_plus1_IFID <= '0;
      valid_IFID    <= 1'b0;
      fetch_wait    <= 1'b0;
    end else if (kill) begin
      instr_IFID    <= '0;
      pc_IFID       <= '0;
      pc_plus1_IFID <= '0;
      valid_IFID    <= 1'b0;
      fetch_wait    <= 1'b0;
    end else if (stall_IFID | ~ir_write) begin
      instr_IFID    <= instr_IFID;
      pc_IFID       <= pc_IFID;
      pc_plus1_IFID <= pc_plus1_IFID;
      valid_IFID    <= valid_IFID;
      fetch_wait    <= fetch_wait;
    end else if (load_ifid) begin
      instr_IFID    <= load_data;
      pc_IFID       <= pc;
      pc_plus1_IFID <= pc_inc;
      valid_IFID    <= 1'b1;
      fetch_wait    <= 1'b0;
    end else begin
      instr_IFID    <= '0;
      pc_IFID       <= '0;
      pc_plus1_IFID <= '0;
      valid_IFID    <= 1'b0;
      fetch_wait    <= 1'b1;
    end
  end

endmodule
